// File: rtl/class_fifo.sv
// Per-class circular FIFO with registered read data, occupancy count,
// threshold flags and sticky overflow/underflow error flags.
module class_fifo #(
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AfTh     = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AeTh     = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full_w, empty_w;
  logic push_ok, pop_ok;

  assign full_w  = (count_q == DepthCnt);
  assign empty_w = (count_q == '0);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop_ok  = pop && !empty_w;
  assign push_ok = push && (!full_w || pop_ok);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;
    udf_d      = udf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (push) begin
      ovf_d = 1'b1;
    end

    if (pop_ok) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
      valid_d    = 1'b1;
    end else if (pop) begin
      udf_d = 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // Storage is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_L && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out      = data_out_q;
  assign valid_out     = valid_q;
  assign count         = count_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign almost_full   = (count_q >= AfTh);
  assign almost_empty  = (count_q <= AeTh);
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule

// File: tb/tb_class_fifo.sv
// Directed self-checking bench for class_fifo with hand-computed expectations.
module tb_class_fifo;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [11:0] data_in;
  logic        push;
  logic        pop;
  logic [11:0] data_out;
  logic        valid_out;
  logic [3:0]  count;
  logic        full, empty, almost_full, almost_empty;
  logic        overflow_err, underflow_err;

  int n_pass = 0;
  int n_total = 0;

  class_fifo #(
    .DATA_WIDTH(12),
    .ADDR_WIDTH(3),
    .ALMOST_FULL_TH(6),
    .ALMOST_EMPTY_TH(2)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .data_in(data_in),
    .push(push),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .count(count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one cycle of stimulus and sample 1 time unit after the edge.
  task automatic step(input logic rst_n, input logic ps, input logic pp, input logic [11:0] d);
    reset_L = rst_n;
    push    = ps;
    pop     = pp;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;

    // Reset with push held high
    step(1'b0, 1'b1, 1'b0, 12'h777);
    step(1'b0, 1'b1, 1'b0, 12'h777);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_udf", underflow_err, 0);

    // Fill 0x001..0x008
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 12'(i));
      chk("fill_count", count, i);
      chk("fill_afull", almost_full, (i >= 6));
      chk("fill_full", full, (i == 8));
      chk("fill_aempty", almost_empty, (i <= 2));
      chk("fill_valid", valid_out, 0);
    end

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 12'h000);
      chk("drain_dout", data_out, i);
      chk("drain_valid", valid_out, 1);
      chk("drain_count", count, 8 - i);
    end
    chk("drain_empty", empty, 1);
    step(1'b1, 1'b0, 1'b0, 12'h000);
    chk("idle_valid", valid_out, 0);
    chk("idle_hold", data_out, 12'h008);

    // Refill, then overflow
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 12'(12'h010 + i));
    chk("refill_full", full, 1);
    step(1'b1, 1'b1, 1'b0, 12'hABC);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_count", count, 8);
    chk("ovf_udf", underflow_err, 0);

    // Push and pop while full: both accepted, no new error
    step(1'b1, 1'b1, 1'b1, 12'h0AA);
    chk("fullpp_dout", data_out, 12'h011);
    chk("fullpp_valid", valid_out, 1);
    chk("fullpp_count", count, 8);

    for (int i = 2; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 12'h000);
      chk("ovf_drain", data_out, 12'h010 + i);
    end
    step(1'b1, 1'b0, 1'b1, 12'h000);
    chk("ovf_drain_last", data_out, 12'h0AA);
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", overflow_err, 1);

    // Underflow with simultaneous push: no fall-through
    step(1'b1, 1'b1, 1'b1, 12'h055);
    chk("udf_flag", underflow_err, 1);
    chk("udf_valid", valid_out, 0);
    chk("udf_count", count, 1);
    chk("udf_hold", data_out, 12'h0AA);
    step(1'b1, 1'b0, 1'b1, 12'h000);
    chk("udf_next", data_out, 12'h055);
    chk("udf_next_valid", valid_out, 1);
    chk("udf_next_count", count, 0);

    // Wrap-around at count 3
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 12'(12'h100 + i));
    chk("wrap_pre_count", count, 3);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b1, 12'(12'h103 + k));
      chk("wrap_dout", data_out, 12'h100 + k);
      chk("wrap_count", count, 3);
      chk("wrap_valid", valid_out, 1);
    end

    // Mid-stream reset at count 5
    step(1'b1, 1'b1, 1'b0, 12'h200);
    step(1'b1, 1'b1, 1'b0, 12'h201);
    chk("mid_count5", count, 5);
    step(1'b0, 1'b0, 1'b0, 12'h000);
    chk("mid_count0", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_ovf", overflow_err, 0);
    chk("mid_udf", underflow_err, 0);
    chk("mid_dout", data_out, 0);
    step(1'b1, 1'b1, 1'b0, 12'h123);
    chk("mid_push_count", count, 1);
    step(1'b1, 1'b0, 1'b1, 12'h000);
    chk("mid_pop_dout", data_out, 12'h123);
    chk("mid_pop_valid", valid_out, 1);
    chk("mid_pop_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
